babbage_req_arbiter: RTL

Shares one Babbage difference engine between NUM_REQ independent requesters. Each requester presents an n value. The block grants requesters in round-robin order, starts the engine, waits for its done pulse (or a timeout), then returns the BCD result to the granted requester with a one-cycle ack. It sits between the user-facing logic (switches/UART/display muxes) and the engine instance.

---
 rtl/babbage_req_arbiter_pkg.sv | 22 ++
 rtl/babbage_req_arbiter_if.sv | 38 +++
 rtl/babbage_req_arbiter_rr_pick.sv | 41 ++++
 rtl/babbage_req_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/babbage_req_arbiter_pkg.sv
// Shared types and constants for the Babbage engine request arbiter.
//   arb_state_t : arbiter FSM states
//   BCD_DIGITS  : number of BCD digits in a result
//   BCD_ERR     : result value reported on an engine timeout
//   clog2_min1  : index width that never collapses to zero bits
package babbage_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

  localparam int BCD_DIGITS = 4;
  localparam logic [4*BCD_DIGITS-1:0] BCD_ERR = 16'hFFFF;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/babbage_req_arbiter_if.sv
// Bundle between the arbiter, its requesters and the shared engine.
//   master : arbiter side (drives ack/result/engine controls)
//   slave  : environment side (requesters + engine)
//   req/req_n/ack/result_*   requester handshake
//   eng_*                    engine handshake
//   busy/grant_id            status
interface babbage_req_arbiter_if
  import babbage_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int INPUT_WIDTH = 5
);
  localparam int GW    = clog2_min1(NUM_REQ);
  localparam int BCD_W = 4 * BCD_DIGITS;

  logic [NUM_REQ-1:0]                  req;
  logic [NUM_REQ-1:0][INPUT_WIDTH-1:0] req_n;
  logic [NUM_REQ-1:0]                  ack;
  logic [BCD_W-1:0]                    result_bcd;
  logic                                result_err;
  logic                                eng_start;
  logic [INPUT_WIDTH-1:0]              eng_n;
  logic                                eng_done;
  logic [BCD_W-1:0]                    eng_bcd;
  logic                                busy;
  logic [GW-1:0]                       grant_id;

  modport master (
    input  req, req_n, eng_done, eng_bcd,
    output ack, result_bcd, result_err, eng_start, eng_n, busy, grant_id
  );

  modport slave (
    output req, req_n, eng_done, eng_bcd,
    input  ack, result_bcd, result_err, eng_start, eng_n, busy, grant_id
  );

endinterface

// File: rtl/babbage_req_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   i_req   : request vector
//   i_ptr   : index with highest priority this round
//   o_valid : at least one request set
//   o_idx   : first set request scanning i_ptr, i_ptr+1, ... with wrap
module babbage_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int GW      = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GW-1:0]      i_ptr,
  output logic               o_valid,
  output logic [GW-1:0]      o_idx
);

  logic          w_valid;
  logic [GW-1:0] w_idx;
  logic [GW-1:0] w_j;
  int            w_t;

  // Scan offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    w_valid = 1'b0;
    w_idx   = '0;
    w_j     = '0;
    w_t     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_t = int'(i_ptr) + i;
      if (w_t >= NUM_REQ) w_t = w_t - NUM_REQ;
      w_j = GW'(w_t);
      if (i_req[w_j]) begin
        w_valid = 1'b1;
        w_idx   = w_j;
      end
    end
  end

  assign o_valid = w_valid;
  assign o_idx   = w_idx;

endmodule

// File: rtl/babbage_req_arbiter.sv
// Round-robin arbiter sharing one Babbage difference engine.
//   i_clk, i_reset : clock, async active-high reset
//   bus (master)   : requester handshake, engine handshake, status
//
// state   | meaning
// IDLE    | waiting for any request; grant + latch n on the pick
// ISSUE   | one-cycle engine start, timeout counter loaded
// WAIT    | waiting for eng_done or timeout
// RESPOND | ack the granted requester if still requesting, advance ptr
module babbage_req_arbiter
  import babbage_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int INPUT_WIDTH    = 5,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int OUTPUT_WIDTH   = 14
) (
  input logic                    i_clk,
  input logic                    i_reset,
  babbage_req_arbiter_if.master  bus
);

  localparam int GW    = clog2_min1(NUM_REQ);
  localparam int BCD_W = 4 * BCD_DIGITS;
  // Worst-case engine run; a shorter timeout would cut off legal results,
  // so an undersized setting is raised to this floor.
  localparam int MIN_TIMEOUT = 3 * (2 ** INPUT_WIDTH) + OUTPUT_WIDTH + 2;
  localparam int TIMEOUT_EFF = (TIMEOUT_CYCLES < MIN_TIMEOUT) ? MIN_TIMEOUT : TIMEOUT_CYCLES;
  localparam int TW          = $clog2(TIMEOUT_EFF);

  arb_state_t             r_state, w_state_nxt;
  logic [GW-1:0]          r_ptr, w_ptr_nxt;
  logic [GW-1:0]          r_grant, w_grant_nxt;
  logic [INPUT_WIDTH-1:0] r_eng_n, w_eng_n_nxt;
  logic [TW-1:0]          r_to_cnt, w_to_cnt_nxt;
  logic [BCD_W-1:0]       r_result, w_result_nxt;
  logic                   r_err, w_err_nxt;
  logic                   w_pick_valid;
  logic [GW-1:0]          w_pick_idx;
  logic [NUM_REQ-1:0]     w_ack;

  babbage_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_rr_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_grant_nxt  = r_grant;
    w_eng_n_nxt  = r_eng_n;
    w_to_cnt_nxt = r_to_cnt;
    w_result_nxt = r_result;
    w_err_nxt    = r_err;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_grant_nxt = w_pick_idx;
          w_eng_n_nxt = bus.req_n[w_pick_idx];
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // Down-counter reaches zero on the last permitted WAIT cycle.
        w_to_cnt_nxt = TW'(TIMEOUT_EFF - 1);
        w_state_nxt  = WAIT;
      end
      WAIT: begin
        if (bus.eng_done) begin
          w_result_nxt = bus.eng_bcd;
          w_err_nxt    = 1'b0;
          w_state_nxt  = RESPOND;
        end else if (r_to_cnt == '0) begin
          w_result_nxt = BCD_ERR;
          w_err_nxt    = 1'b1;
          w_state_nxt  = RESPOND;
        end else begin
          w_to_cnt_nxt = r_to_cnt - TW'(1);
        end
      end
      RESPOND: begin
        w_ptr_nxt   = (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + GW'(1);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_grant  <= '0;
      r_eng_n  <= '0;
      r_to_cnt <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_grant  <= w_grant_nxt;
      r_eng_n  <= w_eng_n_nxt;
      r_to_cnt <= w_to_cnt_nxt;
      r_result <= w_result_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // A requester that withdrew before RESPOND gets no ack; the result is still kept.
  always_comb begin
    w_ack = '0;
    if (r_state == RESPOND) w_ack[r_grant] = bus.req[r_grant];
  end

  assign bus.ack        = w_ack;
  assign bus.eng_start  = (r_state == ISSUE);
  assign bus.eng_n      = r_eng_n;
  assign bus.busy       = (r_state != IDLE);
  assign bus.grant_id   = r_grant;
  assign bus.result_bcd = r_result;
  assign bus.result_err = r_err;

endmodule
